// File: rtl/reg_file_wr_demux_if.sv
// Register-file access bundle: one write port (enable, index, data) and
// two combinational read ports (index in, data out).
interface reg_file_wr_demux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) ();

  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  // Datapath side: issues writes and read indices, consumes read data.
  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2,
    input  read_data1, read_data2
  );

  // Register file side.
  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2,
    output read_data1, read_data2
  );

endinterface

// File: rtl/reg_file_wr_demux.sv
// MIPS general-purpose register file. Writes are steered by a one-hot
// write-enable decoder (the write-side inverse of the read multiplexers).
// Index 0 is hardwired to zero and never stored. Reads are combinational
// with no write-through bypass: a same-index write is visible only after
// the clock edge that commits it.
module reg_file_wr_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_file_wr_demux_if.slave     bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0]   w_wr_en;
  logic [DATA_WIDTH-1:0] w_rf [0:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];

  // One-hot write-enable decoder gated by reg_write; en[0] is always 0.
  always_comb begin
    w_wr_en = '0;
    if (bus.reg_write) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        w_wr_en[k] = (bus.write_reg == ADDR_WIDTH'(k));
      end
    end else begin
      w_wr_en = '0;
    end
    w_wr_en[0] = 1'b0;
  end

  // Storage for registers 1..N-1; async clear, load only when selected.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    // Register g: cleared by reset, loads write_data when its enable is set.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_regs[g] <= '0;
      end else if (w_wr_en[g]) begin
        r_regs[g] <= bus.write_data;
      end else begin
        r_regs[g] <= r_regs[g];
      end
    end
  end

  // Readable view of the file with $zero supplied as a constant.
  always_comb begin
    w_rf[0] = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      w_rf[k] = r_regs[k];
    end
  end

  // Two independent combinational read ports.
  always_comb begin
    bus.read_data1 = w_rf[bus.read_reg1];
    bus.read_data2 = w_rf[bus.read_reg2];
  end

endmodule

// File: tb/tb_reg_file_wr_demux.sv
// Self-checking bench for reg_file_wr_demux: directed scenarios plus a
// randomized run, all compared against an array model of the 32 registers.
module tb_reg_file_wr_demux;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk;
  logic rst_n;

  reg_file_wr_demux_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file_wr_demux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: architectural register contents.
  logic [DW-1:0] model [NR];

  int n_compared   = 0;
  int n_mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int idx);
    return (idx == 0) ? 32'h0000_0000 : model[idx];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NR; k++) model[k] = 32'h0000_0000;
  endtask

  // Apply one write (or a disabled write) across one rising edge; returns #1 after it.
  task automatic do_write(input logic we, input int idx, input logic [DW-1:0] data);
    bus.reg_write  = we;
    bus.write_reg  = AW'(idx);
    bus.write_data = data;
    @(posedge clk);
    #1;
    if (we && idx != 0) model[idx] = data;
    bus.reg_write = 1'b0;
  endtask

  // Read every index on both ports and compare against the model.
  task automatic check_all(input string tag);
    for (int k = 0; k < NR; k++) begin
      bus.read_reg1 = AW'(k);
      bus.read_reg2 = AW'(NR - 1 - k);
      #1;
      check($sformatf("%s_p1_r%0d", tag, k), bus.read_data1, model_read(k));
      check($sformatf("%s_p2_r%0d", tag, NR - 1 - k), bus.read_data2, model_read(NR - 1 - k));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.reg_write  = 1'b0;
    bus.write_reg  = 5'd0;
    bus.write_data = 32'h0000_0000;
    bus.read_reg1  = 5'd0;
    bus.read_reg2  = 5'd0;
    model_clear();

    // Power-on reset state
    @(posedge clk); #1;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. Reset clear, asynchronous and write-blocking
    do_write(1'b1, 5, 32'hDEAD_BEEF);
    bus.read_reg1 = 5'd5;
    #1;
    check("rst_preload_r5", bus.read_data1, 32'hDEAD_BEEF);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_async_r5", bus.read_data1, 32'h0000_0000);
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd5;
    bus.write_data = 32'h1111_2222;
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_r5", bus.read_data1, 32'h0000_0000);
    bus.reg_write = 1'b0;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2. Basic write/read
    do_write(1'b1, 8, 32'h1234_5678);
    bus.read_reg1 = 5'd8;
    bus.read_reg2 = 5'd9;
    #1;
    check("basic_r8", bus.read_data1, 32'h1234_5678);
    check("basic_r9", bus.read_data2, 32'h0000_0000);
    do_write(1'b1, 31, 32'hFFFF_FFFF);
    bus.read_reg1 = 5'd31;
    bus.read_reg2 = 5'd31;
    #1;
    check("basic_r31_p1", bus.read_data1, 32'hFFFF_FFFF);
    check("basic_r31_p2", bus.read_data2, 32'hFFFF_FFFF);

    // 3. $zero protection
    do_write(1'b1, 0, 32'hCAFE_F00D);
    bus.read_reg1 = 5'd0;
    #1;
    check("zero_r0", bus.read_data1, 32'h0000_0000);
    for (int k = 0; k < NR; k++) do_write(1'b1, k, 32'(k + 1));
    check_all("zero_all");

    // 4. Write enable gating
    do_write(1'b1, 3, 32'hAAAA_5555);
    for (int n = 0; n < 3; n++) do_write(1'b0, 3, 32'h0000_0000);
    bus.read_reg1 = 5'd3;
    #1;
    check("gate_r3", bus.read_data1, 32'hAAAA_5555);

    // 5. Same-cycle read/write: old value before edge, new value after
    do_write(1'b1, 10, 32'h0000_0001);
    bus.read_reg1  = 5'd10;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd10;
    bus.write_data = 32'h0000_0002;
    #1;
    check("rw_before", bus.read_data1, 32'h0000_0001);
    @(posedge clk); #1;
    model[10] = 32'h0000_0002;
    bus.reg_write = 1'b0;
    check("rw_after", bus.read_data1, 32'h0000_0002);

    // 6. One-hot decode walk
    for (int k = 1; k < NR; k++) begin
      do_write(1'b1, k, 32'h0000_0100 + 32'(k));
      check_all($sformatf("walk%0d", k));
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic          we;
      int            wi;
      logic [DW-1:0] wd;
      int            a1;
      int            a2;
      we = ($urandom_range(3, 0) != 0);
      wi = int'($urandom_range(NR - 1, 0));
      wd = $urandom;
      a1 = ($urandom_range(1, 0) == 1) ? wi : int'($urandom_range(NR - 1, 0));
      a2 = int'($urandom_range(NR - 1, 0));
      bus.reg_write  = we;
      bus.write_reg  = AW'(wi);
      bus.write_data = wd;
      bus.read_reg1  = AW'(a1);
      bus.read_reg2  = AW'(a2);
      #1;
      check($sformatf("rnd%0d_pre_p1", n), bus.read_data1, model_read(a1));
      check($sformatf("rnd%0d_pre_p2", n), bus.read_data2, model_read(a2));
      @(posedge clk); #1;
      if (we && wi != 0) model[wi] = wd;
      bus.reg_write = 1'b0;
      check($sformatf("rnd%0d_post_p1", n), bus.read_data1, model_read(a1));
      check($sformatf("rnd%0d_post_p2", n), bus.read_data2, model_read(a2));
    end
    check_all("rnd_final");

    // Reset asserted mid-cycle with a write pending: reset wins
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd7;
    bus.write_data = 32'h7777_7777;
    #2;
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    bus.reg_write = 1'b0;
    check_all("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/reg_file_wr_demux.md
Name: reg_file_wr_demux

Overview:
- 32-entry x 32-bit MIPS general-purpose register file for the single-cycle datapath.
- The write side routes one write-data word to exactly one register. A 1-to-2^ADDR_WIDTH write-enable demultiplexer (decoder) does the routing; this is the inverse of the read-select multiplexing.
- Two asynchronous read ports feed the ALU operand path.
- One synchronous write port is driven from the writeback stage (RegWrite, write register, write data).

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH = 32

Ports:
clk  input  1  clock; all writes occur on rising edge
rst_n  input  1  asynchronous active-low reset; clears all registers
reg_write  input  1  write enable (RegWrite from control unit)
write_reg  input  ADDR_WIDTH  destination register index
write_data  input  DATA_WIDTH  value to store
read_reg1  input  ADDR_WIDTH  read port 1 index (rs)
read_reg2  input  ADDR_WIDTH  read port 2 index (rt)
read_data1  output  DATA_WIDTH  contents of read_reg1
read_data2  output  DATA_WIDTH  contents of read_reg2

Behaviour:
- Reset:
  - rst_n low clears all 32 registers to 0 immediately, without waiting for clk.
  - While rst_n is low, writes are ignored and read_data1/read_data2 = 0 for any address.
  - Release of rst_n is synchronised externally; the first write can take effect on the first rising clk edge after rst_n is high.
- Write decode:
  - The write_reg decoder produces one-hot en[31:0], gated by reg_write.
  - en[k] = reg_write & (write_reg == k).
  - At most one register updates per edge.
  - Register k loads write_data on the rising clk edge when en[k] = 1; otherwise it holds.
- Register $zero:
  - Index 0 is hardwired to 0, and en[0] is forced 0.
  - A write to register 0 is discarded, and reading index 0 always returns 0.
- Reads:
  - Purely combinational, with zero-cycle latency from read_reg* to read_data*.
  - Both ports may address the same register, and both return the same value.
- Read/write same cycle (same index):
  - Before the edge, read returns the old value; there is no write-through bypass.
  - After the edge, read returns the new value within the same cycle the address is held.
  - This matches single-cycle MIPS, where writeback completes at the edge.
- reg_write low: no register changes regardless of write_reg/write_data.
- X/unknown write_reg with reg_write high is not a legal input; no state guarantee.
- Reset asserted mid-cycle while reg_write is high: reset wins and all registers are 0.
- No internal pipelining; the only state is the 31 writable registers. Total write latency is 1 edge.

Test Plan:
1. Reset clear:
   - Preload r5 = 32'hDEADBEEF, then drive rst_n low between clock edges.
   - Immediately, read_reg1 = 5 gives read_data1 = 0.
   - Hold reg_write = 1 to r5 across 2 edges during reset; r5 stays 0.
2. Basic write/read:
   - With reg_write = 1, write_reg = 8, write_data = 32'h12345678, issue one edge.
   - read_reg1 = 8 then gives 32'h12345678 and read_reg2 = 9 gives 0.
   - Write r31 = 32'hFFFFFFFF; both ports at 31 return 32'hFFFFFFFF.
3. $zero protection:
   - Write write_reg = 0, write_data = 32'hCAFEF00D.
   - read_reg1 = 0 returns 0.
   - Write all 32 indices with value = index + 1; reads return 0 for r0 and k + 1 for r1..r31.
4. Write enable gating:
   - Set r3 = 32'hAAAA5555, then reg_write = 0, write_reg = 3, write_data = 32'h0, and issue 3 edges.
   - r3 still reads 32'hAAAA5555.
5. Same-cycle read/write:
   - Set r10 = 32'h1, then present write_reg = 10, write_data = 32'h2, reg_write = 1, read_reg1 = 10.
   - read_data1 = 32'h1 before the edge and 32'h2 after the edge.
6. One-hot decode:
   - Walk write_reg 1..31 with distinct data 32'h100 + k.
   - After each write, check that only the target register changed (all others compared against the shadow model).
